// File: rtl/uart_rx_frame_ctrl_if.sv
// uart_rx_frame_ctrl_if: serial input, frame configuration and frame result signals of the UART receiver
interface uart_rx_frame_ctrl_if #(
  parameter int MAX_WIDTH = 9,
  parameter int PRESC_W   = 6
);
  logic                 RX_IN;
  logic [PRESC_W-1:0]   Prescale;
  logic [4:0]           DATA_LEN;
  logic                 PAR_EN;
  logic                 PAR_TYP;
  logic                 STP2;
  logic [MAX_WIDTH-1:0] P_DATA;
  logic                 Data_Valid;
  logic                 par_err;
  logic                 stp_err;
  logic                 brk_det;
  logic                 busy;
  modport master (
    output RX_IN, Prescale, DATA_LEN, PAR_EN, PAR_TYP, STP2,
    input  P_DATA, Data_Valid, par_err, stp_err, brk_det, busy
  );
  modport slave (
    input  RX_IN, Prescale, DATA_LEN, PAR_EN, PAR_TYP, STP2,
    output P_DATA, Data_Valid, par_err, stp_err, brk_det, busy
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: UART receive frame controller with majority sampling, parity/stop checks and break detection
module uart_rx_frame_ctrl #(
  parameter int MAX_WIDTH = 9,
  parameter int PRESC_W   = 6
) (
  input logic                 CLK,
  input logic                 RST,
  uart_rx_frame_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT} state_t;
  state_t               state_q;
  logic [PRESC_W-1:0]   p_q, edge_q, half, p_sel;
  logic [4:0]           len_q, bit_q, len_sel;
  logic                 par_en_q, par_typ_q, stp2_q;
  logic [2:0]           smp_q;
  logic                 par_flag_q, stp_flag_q, par_bit_q, s1z_q;
  logic [MAX_WIDTH-1:0] p_data_q;
  logic                 dv_q, par_err_q, stp_err_q, brk_q;
  logic                 dec, last, bit_v, fin, stp_now, s1z, brk;
  always_comb begin
    half    = p_q >> 1;
    last    = edge_q == p_q - PRESC_W'(1);
    // at P=4 the nominal decision cycle lies beyond the bit, so decide together with the third sample
    dec     = edge_q == ((p_q == PRESC_W'(4)) ? PRESC_W'(3) : half + PRESC_W'(2));
    bit_v   = (smp_q[0] & smp_q[1]) | ((smp_q[0] | smp_q[1]) & ((edge_q == half + PRESC_W'(1)) ? bus.RX_IN : smp_q[2]));
    fin     = last && (state_q == STOP2 || (state_q == STOP1 && !stp2_q));
    stp_now = stp_flag_q | (dec & ~bit_v);
    s1z     = (state_q == STOP1 && dec) ? ~bit_v : s1z_q;
    brk     = ~|p_data_q & ~par_bit_q & s1z;
    p_sel   = (bus.Prescale inside {PRESC_W'(4), PRESC_W'(8), PRESC_W'(16), PRESC_W'(32)}) ? bus.Prescale : PRESC_W'(8);
    len_sel = (bus.DATA_LEN < 5'd5) ? 5'd5 : (bus.DATA_LEN > 5'(MAX_WIDTH)) ? 5'(MAX_WIDTH) : bus.DATA_LEN;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      p_q        <= PRESC_W'(8);
      edge_q     <= '0;
      len_q      <= 5'd8;
      bit_q      <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      stp2_q     <= 1'b0;
      smp_q      <= '0;
      par_flag_q <= 1'b0;
      stp_flag_q <= 1'b0;
      par_bit_q  <= 1'b0;
      s1z_q      <= 1'b0;
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      dv_q   <= 1'b0;
      brk_q  <= 1'b0;
      edge_q <= last ? '0 : edge_q + PRESC_W'(1);
      if (edge_q == half - PRESC_W'(1)) smp_q[0] <= bus.RX_IN;
      if (edge_q == half) smp_q[1] <= bus.RX_IN;
      if (edge_q == half + PRESC_W'(1)) smp_q[2] <= bus.RX_IN;
      case (state_q)
        IDLE: begin
          edge_q <= '0;
          if (!bus.RX_IN) begin
            state_q    <= START;
            p_q        <= p_sel;
            len_q      <= len_sel;
            par_en_q   <= bus.PAR_EN;
            par_typ_q  <= bus.PAR_TYP;
            stp2_q     <= bus.STP2;
            bit_q      <= '0;
            p_data_q   <= '0;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
            par_flag_q <= 1'b0;
            stp_flag_q <= 1'b0;
            par_bit_q  <= 1'b0;
            s1z_q      <= 1'b0;
          end
        end
        START: if (dec && bit_v) state_q <= IDLE; else if (last) state_q <= DATA;
        DATA: begin
          if (dec) p_data_q <= p_data_q | (MAX_WIDTH'(bit_v) << bit_q);
          if (last) begin
            bit_q <= (bit_q == len_q - 5'd1) ? 5'd0 : bit_q + 5'd1;
            if (bit_q == len_q - 5'd1) state_q <= par_en_q ? PARITY : STOP1;
          end
        end
        PARITY: begin
          if (dec) begin
            par_bit_q  <= bit_v;
            par_flag_q <= bit_v ^ (^p_data_q) ^ par_typ_q;
          end
          if (last) state_q <= STOP1;
        end
        STOP1: begin
          if (dec) begin
            stp_flag_q <= stp_now;
            s1z_q      <= ~bit_v;
          end
          if (last && stp2_q) state_q <= STOP2;
        end
        STOP2: if (dec) stp_flag_q <= stp_now;
        BRK_WAIT: if (!bus.RX_IN) edge_q <= '0; else if (last) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (fin) begin
        state_q   <= brk ? BRK_WAIT : IDLE;
        brk_q     <= brk;
        stp_err_q <= brk | stp_now;
        par_err_q <= ~brk & par_flag_q;
        dv_q      <= ~brk & ~stp_now & ~par_flag_q;
      end
    end
  end
  assign bus.P_DATA     = p_data_q;
  assign bus.Data_Valid = dv_q;
  assign bus.par_err    = par_err_q;
  assign bus.stp_err    = stp_err_q;
  assign bus.brk_det    = brk_q;
  assign bus.busy       = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: scoreboard bench; expected frame results are queued as frames are sent and checked at each frame end
module tb_uart_rx_frame_ctrl;
  typedef struct packed {
    logic       dv;
    logic       brk;
    logic       pe;
    logic       se;
    logic [8:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   evt_cyc = 0;
  int   brk_cyc = 0;
  exp_t sb[$];
  exp_t m_e;
  logic busy_prev = 1'b0;
  logic dv_prev = 1'b0;
  logic brk_prev = 1'b0;

  uart_rx_frame_ctrl_if #(.MAX_WIDTH(9), .PRESC_W(6)) bus ();
  uart_rx_frame_ctrl #(.MAX_WIDTH(9), .PRESC_W(6)) dut (.CLK(clk), .RST(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_prev = 1'b0;
      dv_prev   = 1'b0;
      brk_prev  = 1'b0;
    end else begin
      if (dv_prev) begin
        n_chk++;
        if (bus.Data_Valid !== 1'b0) begin n_fail++; $display("FAIL dv_pulse_width: Data_Valid=%b, required 0", bus.Data_Valid); end
      end
      if (brk_prev) begin
        n_chk++;
        if (bus.brk_det !== 1'b0) begin n_fail++; $display("FAIL brk_pulse_width: brk_det=%b, required 0", bus.brk_det); end
      end
      if (bus.Data_Valid === 1'b1 || bus.brk_det === 1'b1 || (busy_prev && bus.busy === 1'b0)) begin
        evt_cyc = cyc;
        if (bus.brk_det === 1'b1) brk_cyc = cyc;
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_frame_end: dv=%b brk=%b data=%h, required no event", bus.Data_Valid, bus.brk_det, bus.P_DATA);
        end else begin
          m_e = sb.pop_front();
          n_chk++;
          if (bus.Data_Valid !== m_e.dv) begin n_fail++; $display("FAIL data_valid: got %b required %b", bus.Data_Valid, m_e.dv); end
          n_chk++;
          if (bus.brk_det !== m_e.brk) begin n_fail++; $display("FAIL brk_det: got %b required %b", bus.brk_det, m_e.brk); end
          n_chk++;
          if (bus.par_err !== m_e.pe) begin n_fail++; $display("FAIL par_err: got %b required %b", bus.par_err, m_e.pe); end
          n_chk++;
          if (bus.stp_err !== m_e.se) begin n_fail++; $display("FAIL stp_err: got %b required %b", bus.stp_err, m_e.se); end
          n_chk++;
          if (bus.P_DATA !== m_e.data) begin n_fail++; $display("FAIL p_data: got %h required %h", bus.P_DATA, m_e.data); end
        end
      end
      busy_prev = bus.busy;
      dv_prev   = bus.Data_Valid;
      brk_prev  = bus.brk_det;
    end
  end

  function automatic exp_t model(input logic [8:0] d, input logic pen, ptyp, pbit, stp2, s1, s2);
    exp_t e;
    e.data = d;
    e.brk  = (d == 9'd0) && !(pen && pbit) && !s1;
    e.pe   = !e.brk && pen && (pbit != ((^d) ^ ptyp));
    e.se   = e.brk || !s1 || (stp2 && !s2);
    e.dv   = !e.brk && !e.pe && !e.se;
    return e;
  endfunction

  task automatic set_cfg(input int p, input int len, input logic pen, ptyp, stp2);
    bus.Prescale = 6'(p);
    bus.DATA_LEN = 5'(len);
    bus.PAR_EN   = pen;
    bus.PAR_TYP  = ptyp;
    bus.STP2     = stp2;
  endtask

  task automatic drive_bit(input logic b, input int p);
    bus.RX_IN = b;
    repeat (p) @(negedge clk);
  endtask

  task automatic frame(input int p, input logic [8:0] d, input int len, input logic pen, ptyp, pbit, stp2, s1, s2);
    sb.push_back(model(d, pen, ptyp, pbit, stp2, s1, s2));
    drive_bit(1'b0, p);
    for (int i = 0; i < len; i++) drive_bit(d[i], p);
    if (pen) drive_bit(pbit, p);
    drive_bit(s1, p);
    if (stp2) drive_bit(s2, p);
    bus.RX_IN = 1'b1;
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && (sb.size() != 0 || bus.busy !== 1'b0); i++) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.RX_IN = 1'b1;
    set_cfg(8, 8, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({bus.P_DATA, bus.Data_Valid, bus.par_err, bus.stp_err, bus.brk_det, bus.busy} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", {bus.P_DATA, bus.Data_Valid, bus.par_err, bus.stp_err, bus.brk_det, bus.busy});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy=%b required 0", bus.busy); end
  endtask

  task automatic test_basic();
    int c0;
    set_cfg(8, 8, 1'b0, 1'b0, 1'b0);
    c0 = cyc;
    frame(8, 9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_done(200);
    n_chk++;
    if (evt_cyc - c0 != 81) begin n_fail++; $display("FAIL basic_latency: got %0d cycles required 81", evt_cyc - c0); end
  endtask

  task automatic test_parity();
    set_cfg(16, 7, 1'b1, 1'b0, 1'b0);
    frame(16, 9'h055, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_done(300);
    frame(16, 9'h055, 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_done(300);
  endtask

  task automatic test_stop2();
    set_cfg(4, 9, 1'b1, 1'b1, 1'b1);
    frame(4, 9'h1C3, 9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_done(100);
    frame(4, 9'h1C3, 9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_done(100);
  endtask

  task automatic test_glitch();
    int c0;
    set_cfg(8, 8, 1'b0, 1'b0, 1'b0);
    c0 = cyc;
    sb.push_back('{dv: 1'b0, brk: 1'b0, pe: 1'b0, se: 1'b0, data: 9'h000});
    drive_bit(1'b0, 2);
    bus.RX_IN = 1'b1;
    wait_done(50);
    n_chk++;
    if (evt_cyc - c0 != 8) begin n_fail++; $display("FAIL glitch_idle_time: got %0d cycles required 8", evt_cyc - c0); end
  endtask

  task automatic test_clamp();
    set_cfg(5, 3, 1'b0, 1'b0, 1'b0);
    frame(8, 9'h015, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_done(200);
    set_cfg(8, 20, 1'b0, 1'b0, 1'b0);
    frame(8, 9'h155, 9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_done(200);
  endtask

  task automatic test_break();
    int c0;
    set_cfg(8, 8, 1'b0, 1'b0, 1'b0);
    c0 = cyc;
    sb.push_back('{dv: 1'b0, brk: 1'b1, pe: 1'b0, se: 1'b1, data: 9'h000});
    sb.push_back('{dv: 1'b0, brk: 1'b0, pe: 1'b0, se: 1'b1, data: 9'h000});
    drive_bit(1'b0, 96);
    drive_bit(1'b1, 5);
    drive_bit(1'b0, 1);
    bus.RX_IN = 1'b1;
    wait_done(100);
    n_chk++;
    if (brk_cyc - c0 != 81) begin n_fail++; $display("FAIL brk_latency: got %0d cycles required 81", brk_cyc - c0); end
    n_chk++;
    if (evt_cyc - c0 != 110) begin n_fail++; $display("FAIL brk_wait_exit: got %0d cycles required 110", evt_cyc - c0); end
    frame(8, 9'h03C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_done(200);
  endtask

  task automatic test_back_to_back();
    int c0;
    set_cfg(8, 8, 1'b0, 1'b0, 1'b0);
    c0 = cyc;
    frame(8, 9'h081, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    frame(8, 9'h07E, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_done(300);
    n_chk++;
    if (evt_cyc - c0 != 162) begin n_fail++; $display("FAIL back_to_back_latency: got %0d cycles required 162", evt_cyc - c0); end
  endtask

  task automatic test_cfg_change();
    set_cfg(8, 8, 1'b0, 1'b0, 1'b0);
    fork
      frame(8, 9'h096, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      begin
        repeat (30) @(negedge clk);
        set_cfg(16, 5, 1'b1, 1'b1, 1'b1);
      end
    join
    wait_done(200);
    set_cfg(8, 8, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    set_cfg(8, 8, 1'b0, 1'b0, 1'b0);
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 20);
    n_chk++;
    if (bus.P_DATA !== 9'h003 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_frame_state: P_DATA=%h busy=%b required 003 and 1", bus.P_DATA, bus.busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.P_DATA, bus.Data_Valid, bus.par_err, bus.stp_err, bus.brk_det, bus.busy} !== 14'd0) begin
      n_fail++;
      $display("FAIL mid_frame_reset: got %h required 0", {bus.P_DATA, bus.Data_Valid, bus.par_err, bus.stp_err, bus.brk_det, bus.busy});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame(8, 9'h05A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_done(200);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_stop2();
    test_glitch();
    test_clamp();
    test_break();
    test_back_to_back();
    test_cfg_change();
    test_reset_mid();
    n_chk++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drained: %0d entries left, required 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
